// File: rtl/poly_pointwise_montgomery_pkg.sv
// Package: poly_pointwise_montgomery_pkg
// Shared constants and FSM encoding for the pointwise Montgomery multiplier.
//   N       coefficients per polynomial
//   ADDR_W  RAM address width (2^ADDR_W >= N)
//   COEF_W  signed coefficient width
//   PROD_W  signed product width handed to the reducer
//   Q/QINV  Dilithium modulus and its inverse mod 2^32 (used by the reducer)
package poly_pointwise_montgomery_pkg;

    localparam int N      = 256;
    localparam int ADDR_W = 8;
    localparam int COEF_W = 32;
    localparam int PROD_W = 2 * COEF_W;

    localparam logic signed [COEF_W-1:0] Q    = 32'sd8380417;
    localparam logic signed [COEF_W-1:0] QINV = 32'sd58728449;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_MUL   = 3'd2,
        S_ISSUE = 3'd3,
        S_WAIT  = 3'd4,
        S_WRITE = 3'd5,
        S_DONE  = 3'd6
    } state_t;

endpackage

// File: rtl/poly_pointwise_montgomery.sv
// Module: poly_pointwise_montgomery
// Walks N coefficient pairs from RAMs A and B, forms the signed 64-bit product
// a[i]*b[i], hands it to an external Montgomery reducer over an RTR/RTS
// handshake and writes the reduced result to RAM C.
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   start, busy, done   pass control (start pulse, busy level, done pulse)
//   a_addr/a_rdata      RAM A read port (synchronous read, 1-cycle latency)
//   b_addr/b_rdata      RAM B read port (same timing as A)
//   c_addr/c_wdata/c_we RAM C write port
//   red_a/red_rtr       product and one-cycle request to the reducer
//   red_rts/red_t       reducer result valid and signed result
module poly_pointwise_montgomery
    import poly_pointwise_montgomery_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [ADDR_W-1:0]        a_addr,
    input  logic signed [COEF_W-1:0] a_rdata,
    output logic [ADDR_W-1:0]        b_addr,
    input  logic signed [COEF_W-1:0] b_rdata,
    output logic [ADDR_W-1:0]        c_addr,
    output logic signed [COEF_W-1:0] c_wdata,
    output logic                     c_we,
    output logic signed [PROD_W-1:0] red_a,
    output logic                     red_rtr,
    input  logic                     red_rts,
    input  logic signed [COEF_W-1:0] red_t
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

    state_t                     state;
    logic [ADDR_W-1:0]          idx;
    logic signed [PROD_W-1:0]   prod;
    logic signed [PROD_W-1:0]   a_ext;
    logic signed [PROD_W-1:0]   b_ext;

    // Sign-extend before multiplying so the full 64-bit product is kept.
    assign a_ext = a_rdata;
    assign b_ext = b_rdata;

    // The product register only changes in MUL, so the reducer sees a stable
    // operand from ISSUE through the cycle its result is captured.
    assign red_a = prod;

    // NOTE: non-blocking assignments throughout, so every branch below reads
    // the pre-edge value of state, idx and the other registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            idx     <= '0;
            prod    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            a_addr  <= '0;
            b_addr  <= '0;
            c_addr  <= '0;
            c_wdata <= '0;
            c_we    <= 1'b0;
            red_rtr <= 1'b0;
        end else begin
            // Single-cycle strobes fall back to zero unless a state raises them.
            done    <= 1'b0;
            c_we    <= 1'b0;
            red_rtr <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        idx    <= '0;
                        a_addr <= '0;
                        b_addr <= '0;
                        busy   <= 1'b1;
                        state  <= S_READ;
                    end
                end

                // Address is already on the RAM ports; the RAMs sample it at
                // the end of this cycle.
                S_READ: state <= S_MUL;

                // Read data is valid here. A stale RTS from the previous
                // coefficient holds us in MUL: the reducer only drops RTS while
                // RTR is low, so a request now would be lost.
                S_MUL: begin
                    prod <= a_ext * b_ext;
                    if (!red_rts) begin
                        red_rtr <= 1'b1;
                        state   <= S_ISSUE;
                    end
                end

                S_ISSUE: state <= S_WAIT;

                S_WAIT: begin
                    if (red_rts) begin
                        c_wdata <= red_t;
                        c_addr  <= idx;
                        c_we    <= 1'b1;
                        state   <= S_WRITE;
                    end
                end

                S_WRITE: begin
                    if (idx == LAST_IDX) begin
                        state <= S_DONE;
                    end else begin
                        idx    <= idx + 1'b1;
                        a_addr <= idx + 1'b1;
                        b_addr <= idx + 1'b1;
                        state  <= S_READ;
                    end
                end

                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_poly_pointwise_montgomery.sv
// Testbench: tb_poly_pointwise_montgomery
// Drives poly_pointwise_montgomery with behavioural RAMs and a 3-stage
// Montgomery reducer model; expected writes are queued when RAM contents are
// loaded and popped as the DUT writes RAM C.
module tb_poly_pointwise_montgomery;
    import poly_pointwise_montgomery_pkg::*;

    logic                     clock;
    logic                     reset;
    logic                     start;
    logic                     busy;
    logic                     done;
    logic [ADDR_W-1:0]        a_addr;
    logic signed [COEF_W-1:0] a_rdata;
    logic [ADDR_W-1:0]        b_addr;
    logic signed [COEF_W-1:0] b_rdata;
    logic [ADDR_W-1:0]        c_addr;
    logic signed [COEF_W-1:0] c_wdata;
    logic                     c_we;
    logic signed [PROD_W-1:0] red_a;
    logic                     red_rtr;
    logic                     red_rts;
    logic signed [COEF_W-1:0] red_t;

    int checks   = 0;
    int failures = 0;

    poly_pointwise_montgomery dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .a_addr  (a_addr),
        .a_rdata (a_rdata),
        .b_addr  (b_addr),
        .b_rdata (b_rdata),
        .c_addr  (c_addr),
        .c_wdata (c_wdata),
        .c_we    (c_we),
        .red_a   (red_a),
        .red_rtr (red_rtr),
        .red_rts (red_rts),
        .red_t   (red_t)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Reference Montgomery reduction: a * 2^-32 mod q, result in (-q, q).
    function automatic logic signed [31:0] mont(input logic signed [63:0] a);
        logic signed [31:0] t;
        logic signed [63:0] t64;
        logic signed [63:0] r;
        t   = 32'(a * 64'sd58728449);
        t64 = t;
        r   = (a - t64 * 64'sd8380417) >>> 32;
        return r[31:0];
    endfunction

    // Behavioural RAMs A and B with synchronous read.
    logic signed [COEF_W-1:0] a_mem [N];
    logic signed [COEF_W-1:0] b_mem [N];

    always @(posedge clock) begin
        a_rdata <= a_mem[a_addr];
        b_rdata <= b_mem[b_addr];
    end

    // Reducer model: samples RTR, raises RTS three edges later, clears RTS only
    // on an edge where RTR is low (optionally after hold_extra more cycles).
    int                       hold_extra = 0;
    int                       hold_cnt;
    logic                     st1, st2, st3;
    logic signed [PROD_W-1:0] a_cap;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            st1      <= 1'b0;
            st2      <= 1'b0;
            st3      <= 1'b0;
            a_cap    <= '0;
            red_rts  <= 1'b0;
            red_t    <= '0;
            hold_cnt <= 0;
        end else begin
            st1 <= red_rtr;
            if (red_rtr) a_cap <= red_a;
            st2 <= st1;
            st3 <= st2;
            if (st3) check("red_a_stable_capture", red_a, a_cap);
            if (st2) begin
                check("red_a_stable_final", red_a, a_cap);
                red_rts  <= 1'b1;
                red_t    <= mont(red_a);
                hold_cnt <= hold_extra;
            end else if (red_rts && !red_rtr) begin
                if (hold_cnt > 0) hold_cnt <= hold_cnt - 1;
                else              red_rts  <= 1'b0;
            end
        end
    end

    // Scoreboard of expected RAM C writes, in address order.
    typedef struct {
        logic [ADDR_W-1:0]        addr;
        logic signed [COEF_W-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   wr_count;
    logic prev_rtr;

    always @(negedge clock) begin
        if (reset) begin
            if (c_we) begin
                wr_count++;
                if (sb.size() == 0) begin
                    check("extra_write", 1'b1, 1'b0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("c_addr", c_addr, e.addr);
                    check("c_wdata", c_wdata, e.data);
                end
            end
            if (red_rtr) begin
                check("rtr_single_cycle", prev_rtr, 1'b0);
                check("rtr_without_stale_rts", red_rts, 1'b0);
            end
            prev_rtr = red_rtr;
        end else begin
            prev_rtr = 1'b0;
        end
    end

    // mode 0: all zero; mode 1: a=1, b=2^32 mod q; mode 2: random |x|<q.
    task automatic load(input int mode);
        logic signed [63:0] pa, pb;
        exp_t e;
        sb.delete();
        for (int i = 0; i < N; i++) begin
            case (mode)
                0:       begin a_mem[i] = 0; b_mem[i] = 0; end
                1:       begin a_mem[i] = 1; b_mem[i] = 32'sd4193792; end
                default: begin
                    a_mem[i] = $signed($urandom_range(0, 2 * 8380416)) - 32'sd8380416;
                    b_mem[i] = $signed($urandom_range(0, 2 * 8380416)) - 32'sd8380416;
                end
            endcase
            pa     = a_mem[i];
            pb     = b_mem[i];
            e.addr = ADDR_W'(i);
            e.data = mont(pa * pb);
            sb.push_back(e);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},    busy,    1'b0);
        check({tag, "_done"},    done,    1'b0);
        check({tag, "_a_addr"},  a_addr,  '0);
        check({tag, "_b_addr"},  b_addr,  '0);
        check({tag, "_c_addr"},  c_addr,  '0);
        check({tag, "_c_wdata"}, c_wdata, '0);
        check({tag, "_c_we"},    c_we,    1'b0);
        check({tag, "_red_a"},   red_a,   '0);
        check({tag, "_red_rtr"}, red_rtr, 1'b0);
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    // One full pass; rp1/rp2 re-pulse start at those cycles, exp_cyc is the
    // cycle count (from the accepted start edge) at which done must be seen.
    task automatic run_pass(input string tag, input int rp1, input int rp2, input int exp_cyc);
        int cyc;
        int done_cyc;
        int ndone;
        wr_count = 0;
        done_cyc = -1;
        ndone    = 0;
        pulse_start();
        check({tag, "_busy_after_start"}, busy, 1'b1);
        cyc = 0;
        while (done_cyc < 0 && cyc < 5000) begin
            @(posedge clock);
            cyc++;
            #1;
            start = (cyc == rp1 || cyc == rp2);
            if (done) begin
                done_cyc = cyc;
                ndone++;
            end
        end
        start = 1'b0;
        if (done_cyc < 0) begin
            check({tag, "_done_timeout"}, 1'b0, 1'b1);
        end else begin
            check({tag, "_done_cycle"}, done_cyc, exp_cyc);
            check({tag, "_busy_at_done"}, busy, 1'b0);
            for (int k = 0; k < 12; k++) begin
                @(posedge clock);
                #1;
                if (done) ndone++;
            end
            check({tag, "_done_pulses"}, ndone, 1);
            check({tag, "_busy_idle"}, busy, 1'b0);
        end
        check({tag, "_write_count"}, wr_count, N);
        check({tag, "_sb_empty"}, sb.size(), 0);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_outputs_zero("reset");
        @(negedge clock);
        reset = 1'b1;

        // All-zero polynomials.
        load(0);
        run_pass("zero", -1, -1, 7 * N + 1);

        // a=1, b=2^32 mod q gives 1 mod q everywhere.
        load(1);
        run_pass("unity", -1, -1, 7 * N + 1);

        // Random operands against the reference reduction.
        load(2);
        run_pass("random", -1, -1, 7 * N + 1);

        // Start re-pulsed mid-pass is ignored.
        load(2);
        run_pass("repulse", 5, 900, 7 * N + 1);

        // Reset at cycle 400 of a pass, then a clean pass.
        load(2);
        pulse_start();
        repeat (400) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check_outputs_zero("midreset");
        @(posedge clock);
        #1;
        check_outputs_zero("midreset_edge");
        sb.delete();
        @(negedge clock);
        reset = 1'b1;
        load(2);
        run_pass("after_reset", -1, -1, 7 * N + 1);

        // Reducer holds RTS 4 extra cycles: the FSM waits in MUL, adding
        // two cycles per coefficient after the first.
        hold_extra = 4;
        load(2);
        run_pass("stale_rts", -1, -1, 9 * N - 1);
        hold_extra = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
